warp_scheduler: RTL and testbench
=================================

# warp_scheduler

Round-robin warp scheduler that sequences the 16-lane SIMD core. It holds a PC and state per warp and arbitrates the single instruction-memory fetch port between warps. It presents one decoded instruction at a time to the shared lane datapath (ALU plus register files) over a valid/ready issue port, and tracks completion per warp. It sits between `gpu_top`'s instruction memory and the lane array, replacing the single-thread fetch loop.

## Interface
- `NUM_WARPS`, 4: number of warps; must be ≥2 and a power of two.
- `PC_W`, 8: instruction address width.
- `INSTR_W`, 32: instruction width; opcode is `[15:12]`, rd `[11:8]`, rs2 `[7:4]`, rs1 `[3:0]`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch pulse; sampled only while idle.
- `base_pc`  in  PC_W  start PC loaded into every enabled warp on `start`.
- `warp_mask`  in  NUM_WARPS  warps enabled by `start`.
- `imem_req`  out  1  one-cycle fetch request pulse.
- `imem_addr`  out  PC_W  fetch address; valid with `imem_req`.
- `imem_valid`  in  1  fetch response strobe; arrives ≥1 cycle after `imem_req`.
- `imem_rdata`  in  INSTR_W  fetched instruction; valid with `imem_valid`.
- `issue_valid`  out  1  instruction offered to the datapath.
- `issue_ready`  in  1  datapath accepts the instruction.
- `issue_instr`  out  INSTR_W  instruction being issued.
- `issue_warp`  out  $clog2(NUM_WARPS)  warp that owns `issue_instr`.
- `wb_valid`  in  1  datapath completion strobe.
- `wb_warp`  in  $clog2(NUM_WARPS)  warp that completed.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when all enabled warps have halted.
- `err`  out  1  sticky flag for protocol violations; cleared only by reset or an accepted `start`.

## Operation
- Per-warp state machine: IDLE → READY → FETCH → ISSUE → EXEC → READY, repeating until DONE.
- Accepted `start` (only when `busy`=0): every masked warp goes READY with PC = `base_pc`. Unmasked warps go to DONE.
- Fetch arbiter: at most one outstanding fetch. When no fetch is outstanding, round-robin over READY warps. The granted warp pulses `imem_req` with its PC and goes to FETCH.
- On `imem_valid`, the FETCH warp latches `imem_rdata` and its PC advances by 1, wrapping modulo 2^PC_W.
  - Opcode 4'hF (HALT): the warp goes to DONE and nothing is issued.
  - Any other opcode: the warp goes to ISSUE.
- Issue arbiter: round-robin over ISSUE warps. Once `issue_valid` rises, `issue_instr` and `issue_warp` stay stable until `issue_valid && issue_ready`. On that handshake the warp goes to EXEC.
- `wb_valid` for a warp in EXEC moves it to READY. `wb_valid` for a warp in any other state is ignored and sets `err`.
- `imem_valid` with no fetch outstanding is ignored and sets `err`.
- Round-robin rule for both arbiters: the priority pointer moves to grant+1, modulo NUM_WARPS. After reset or `start` the pointer is 0.
- `done` fires in the cycle after the last enabled warp reaches DONE. In that same cycle `busy` falls and all warps return to IDLE.
- `start` with `warp_mask`=0: `done` pulses the cycle after `start`, `busy` never rises, no fetch is issued.
- `start` while `busy`=1 is ignored, with no error.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `issue_valid`=0, `issue_instr`=0, `issue_warp`=0, `busy`=0, `done`=0, `err`=0. All warps IDLE and all PCs 0.
- `start` at edge T → `busy`=1 and the first `imem_req` both at T+1.
- `imem_valid` at edge T → if the instruction is not HALT, `issue_valid` can be high at T+1. A new `imem_req` can be issued at T+1.
- Issue handshake at edge T → the next `issue_valid` for another warp can be high at T+1, giving back-to-back issue.
- `wb_valid` at edge T → that warp can fetch at T+1.
- Simultaneous events in one cycle are all handled in that cycle: `imem_valid`, an issue handshake and `wb_valid`, as long as they concern different warps.
- Reset asserted mid-operation: all state clears immediately. No `done` pulse. Late `imem_valid`/`wb_valid` after reset release set `err`.

## Structure
- `gpu_pkg` holds:
  - opcode enum: `OP_ADD`=0, `OP_SUB`=1, `OP_MUL`=2, `OP_AND`=3, `OP_OR`=4, `OP_XOR`=5, `OP_HALT`=4'hF;
  - `warp_state_t` enum;
  - opcode bit-field constants.
- Sub-module `rr_arbiter` (parameter N; ports `req[N]`, `grant` one-hot, `grant_idx`, `advance`). It is instantiated twice, once for fetch and once for issue.

## Test plan
- Single warp, `warp_mask`=4'b0001, `base_pc`=0, memory holds ADD, SUB, HALT; `issue_ready`=1; `wb_valid` 2 cycles after each issue → exactly 2 issues at PCs 0 and 1, then `done` pulses once and `busy` falls.
- Four warps, each fetching ADD then HALT, `imem_valid` 1 cycle after each `imem_req` → fetch order is warps 0, 1, 2, 3; issue order is 0, 1, 2, 3; exactly 4 issues.
- `issue_ready` held low for 5 cycles while `issue_valid`=1 → `issue_instr` and `issue_warp` stay stable; after release, issue completes exactly once.
- `base_pc`=8'hFF, memory[FF]=ADD, memory[00]=HALT → second fetch address is 8'h00; `done` pulses.
- Protocol violations: `wb_valid` for a warp in READY sets `err`=1, which stays 1 until the next accepted `start`. `warp_mask`=0 with `start` → `done` pulses at T+1 and `imem_req` is never asserted.
- Reset dropped while warp 2 is in EXEC → all outputs return to reset values. A new `start` then runs correctly from `base_pc`.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types for the SIMD core: instruction opcodes, per-warp scheduler
// states and the location of the opcode field inside an instruction word.
package gpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    WS_IDLE  = 3'd0,
    WS_READY = 3'd1,
    WS_FETCH = 3'd2,
    WS_ISSUE = 3'd3,
    WS_EXEC  = 3'd4,
    WS_DONE  = 3'd5
  } warp_state_t;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  function automatic logic is_halt(input logic [3:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/warp_scheduler_if.sv
// Bundle of launch, instruction-fetch, issue and writeback signals around the
// warp scheduler, plus a per-warp state view for checkers.
interface warp_scheduler_if #(
  parameter int NUM_WARPS = 4,
  parameter int PC_W      = 8,
  parameter int INSTR_W   = 32
) ();
  import gpu_pkg::*;
  localparam int WARP_W = $clog2(NUM_WARPS);

  logic                  start;
  logic [PC_W-1:0]       base_pc;
  logic [NUM_WARPS-1:0]  warp_mask;
  logic                  imem_req;
  logic [PC_W-1:0]       imem_addr;
  logic                  imem_valid;
  logic [INSTR_W-1:0]    imem_rdata;
  // Issue port: issue_instr/issue_warp are held stable from the rise of
  // issue_valid until a rising edge sees issue_valid && issue_ready; that edge
  // is the one and only transfer of the instruction.
  logic                  issue_valid;
  logic                  issue_ready;
  logic [INSTR_W-1:0]    issue_instr;
  logic [WARP_W-1:0]     issue_warp;
  logic                  wb_valid;
  logic [WARP_W-1:0]     wb_warp;
  logic                  busy;
  logic                  done;
  logic                  err;
  warp_state_t [NUM_WARPS-1:0] dbg_state;

  modport master (
    input  start, base_pc, warp_mask, imem_valid, imem_rdata, issue_ready,
           wb_valid, wb_warp,
    output imem_req, imem_addr, issue_valid, issue_instr, issue_warp,
           busy, done, err, dbg_state
  );

  modport slave (
    output start, base_pc, warp_mask, imem_valid, imem_rdata, issue_ready,
           wb_valid, wb_warp,
    input  imem_req, imem_addr, issue_valid, issue_instr, issue_warp,
           busy, done, err, dbg_state
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority
// pointer; the pointer moves to grant+1 when the grant is consumed.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] idx;
  logic             found;

  // A clear in the same cycle as a request arbitrates from position 0.
  assign base = clear ? '0 : ptr;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = base + IDX_W'(i);
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                ptr <= '0;
    else if (advance && found) ptr <= grant_idx + 1'b1;
    else if (clear)            ptr <= '0;
  end

endmodule

// File: rtl/warp_scheduler.sv
// Round-robin warp scheduler: per-warp PC/state, one outstanding instruction
// fetch, one instruction offered to the lane datapath at a time.
module warp_scheduler import gpu_pkg::*; #(
  parameter int NUM_WARPS = 4,
  parameter int PC_W      = 8,
  parameter int INSTR_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  warp_scheduler_if.master bus
);
  localparam int WARP_W = $clog2(NUM_WARPS);

  warp_state_t [NUM_WARPS-1:0] state;
  warp_state_t [NUM_WARPS-1:0] state_pre;
  logic [PC_W-1:0]    pc        [NUM_WARPS];
  logic [PC_W-1:0]    pc_pre    [NUM_WARPS];
  logic [INSTR_W-1:0] instr     [NUM_WARPS];
  logic [INSTR_W-1:0] instr_pre [NUM_WARPS];
  logic               fetch_out, fetch_out_pre;
  logic [WARP_W-1:0]  fetch_warp;
  logic               start_acc, viol, all_done;
  logic               fetch_adv, issue_adv, fetch_take, issue_take;
  logic [NUM_WARPS-1:0] fetch_req, issue_req, fetch_grant, issue_grant;
  logic [WARP_W-1:0]  fetch_idx, issue_idx;

  assign start_acc     = bus.start && !bus.busy;
  assign bus.dbg_state = state;

  always_comb begin
    all_done = bus.busy;
    for (int w = 0; w < NUM_WARPS; w++)
      if (state[w] != WS_DONE) all_done = 1'b0;
  end

  // Apply this cycle's launch, fetch response, issue handshake and writeback;
  // the arbiters then choose from the resulting states.
  always_comb begin
    state_pre     = state;
    pc_pre        = pc;
    instr_pre     = instr;
    fetch_out_pre = fetch_out;
    viol          = 1'b0;
    if (start_acc && (|bus.warp_mask)) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_pre[w] = bus.warp_mask[w] ? WS_READY : WS_DONE;
        if (bus.warp_mask[w]) pc_pre[w] = bus.base_pc;
      end
    end
    if (bus.imem_valid) begin
      if (fetch_out) begin
        fetch_out_pre         = 1'b0;
        instr_pre[fetch_warp] = bus.imem_rdata;
        pc_pre[fetch_warp]    = pc[fetch_warp] + 1'b1;
        state_pre[fetch_warp] = is_halt(bus.imem_rdata[OPC_MSB:OPC_LSB]) ? WS_DONE : WS_ISSUE;
      end else begin
        viol = 1'b1;
      end
    end
    if (bus.issue_valid && bus.issue_ready) state_pre[bus.issue_warp] = WS_EXEC;
    if (bus.wb_valid) begin
      if (state[bus.wb_warp] == WS_EXEC) state_pre[bus.wb_warp] = WS_READY;
      else                               viol = 1'b1;
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      fetch_req[w] = (state_pre[w] == WS_READY);
      issue_req[w] = (state_pre[w] == WS_ISSUE);
    end
  end

  assign fetch_adv  = !fetch_out_pre;
  assign issue_adv  = !bus.issue_valid || bus.issue_ready;
  assign fetch_take = fetch_adv && (|fetch_grant);
  assign issue_take = issue_adv && (|issue_grant);

  rr_arbiter #(.N(NUM_WARPS)) u_fetch_arb (
    .clk(clk), .reset(reset), .clear(start_acc), .req(fetch_req),
    .advance(fetch_adv), .grant(fetch_grant), .grant_idx(fetch_idx)
  );

  rr_arbiter #(.N(NUM_WARPS)) u_issue_arb (
    .clk(clk), .reset(reset), .clear(start_acc), .req(issue_req),
    .advance(issue_adv), .grant(issue_grant), .grant_idx(issue_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state[w] <= WS_IDLE;
        pc[w]    <= '0;
        instr[w] <= '0;
      end
      fetch_out       <= 1'b0;
      fetch_warp      <= '0;
      bus.imem_req    <= 1'b0;
      bus.imem_addr   <= '0;
      bus.issue_valid <= 1'b0;
      bus.issue_instr <= '0;
      bus.issue_warp  <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      pc           <= pc_pre;
      instr        <= instr_pre;
      fetch_out    <= fetch_out_pre || fetch_take;
      bus.imem_req <= fetch_take;
      if (fetch_take) begin
        fetch_warp    <= fetch_idx;
        bus.imem_addr <= pc_pre[fetch_idx];
      end
      if (issue_adv) bus.issue_valid <= issue_take;
      if (issue_take) begin
        bus.issue_instr <= instr_pre[issue_idx];
        bus.issue_warp  <= issue_idx;
      end
      bus.err  <= viol || (bus.err && !start_acc);
      bus.done <= all_done || (start_acc && (bus.warp_mask == '0));
      if (start_acc && (|bus.warp_mask)) bus.busy <= 1'b1;
      else if (all_done)                 bus.busy <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (all_done)                                     state[w] <= WS_IDLE;
        else if (fetch_take && (fetch_idx == WARP_W'(w))) state[w] <= WS_FETCH;
        else                                              state[w] <= state_pre[w];
      end
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler: instruction memory and datapath
// responders on the falling edge, directed steps and checks in one initial.
module tb_warp_scheduler;
  import gpu_pkg::*;

  localparam int NW = 4;
  localparam int PW = 8;
  localparam int IW = 32;
  localparam int WW = 2;
  localparam logic [IW-1:0] I_ADD  = 32'h0000_0123;
  localparam logic [IW-1:0] I_SUB  = 32'h0000_1456;
  localparam logic [IW-1:0] I_HALT = 32'h0000_F000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  warp_scheduler_if #(.NUM_WARPS(NW), .PC_W(PW), .INSTR_W(IW)) bus ();

  warp_scheduler #(.NUM_WARPS(NW), .PC_W(PW), .INSTR_W(IW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // ---------------- responders and monitors ----------------
  logic [IW-1:0] mem [256];
  logic          wb_en, stray_imem, stray_wb;
  logic [WW-1:0] stray_wb_warp;
  logic          d0_v = 1'b0, d1_v = 1'b0;
  logic [WW-1:0] d0_w = '0, d1_w = '0;
  logic [PW-1:0] fetch_addr_q [$];
  logic [WW-1:0] fetch_warp_q [$];
  logic [WW-1:0] issue_warp_q [$];
  logic [IW-1:0] issue_instr_q [$];
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.imem_req) begin
      fetch_addr_q.push_back(bus.imem_addr);
      for (int w = 0; w < NW; w++)
        if (bus.dbg_state[w] == WS_FETCH) fetch_warp_q.push_back(w[WW-1:0]);
    end
    if (bus.issue_valid && bus.issue_ready) begin
      issue_warp_q.push_back(bus.issue_warp);
      issue_instr_q.push_back(bus.issue_instr);
    end
    bus.imem_valid = bus.imem_req | stray_imem;
    bus.imem_rdata = mem[bus.imem_addr];
    bus.wb_valid   = d1_v | stray_wb;
    bus.wb_warp    = stray_wb ? stray_wb_warp : d1_w;
    d1_v = d0_v;
    d1_w = d0_w;
    d0_v = bus.issue_valid & bus.issue_ready & wb_en;
    d0_w = bus.issue_warp;
  end

  // ---------------- scoreboard helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int f0, fw0, i0, d0c;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic mark();
    f0  = fetch_addr_q.size();
    fw0 = fetch_warp_q.size();
    i0  = issue_warp_q.size();
    d0c = done_cnt;
  endtask

  task automatic start_run(input logic [NW-1:0] mask, input logic [PW-1:0] base);
    bus.start     = 1'b1;
    bus.warp_mask = mask;
    bus.base_pc   = base;
    tick(1);
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      if (bus.done) seen = 1'b1;
    end
    check(tag, seen, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.start = 1'b0; bus.base_pc = '0; bus.warp_mask = '0; bus.issue_ready = 1'b1;
    wb_en = 1'b1; stray_imem = 1'b0; stray_wb = 1'b0; stray_wb_warp = '0;
    for (int a = 0; a < 256; a++) mem[a] = I_ADD;
    mem[0] = I_ADD; mem[1] = I_SUB; mem[2] = I_HALT;
    mem[16] = I_ADD; mem[17] = I_HALT; mem[8'hFF] = I_ADD;

    tick(3);
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_imem_addr", bus.imem_addr, 0);
    check("rst_issue_valid", bus.issue_valid, 0);
    check("rst_issue_instr", bus.issue_instr, 0);
    check("rst_issue_warp", bus.issue_warp, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    reset = 1'b1;
    tick(2);

    // single warp: ADD, SUB, HALT from pc 0
    mark();
    start_run(4'b0001, 8'h00);
    check("t1_busy_rise", bus.busy, 1);
    check("t1_first_req", bus.imem_req, 1);
    check("t1_first_addr", bus.imem_addr, 8'h00);
    wait_done("t1_done", 40);
    check("t1_busy_fall", bus.busy, 0);
    tick(1);
    check("t1_done_pulse", bus.done, 0);
    check("t1_done_cnt", done_cnt - d0c, 1);
    check("t1_issue_cnt", issue_warp_q.size() - i0, 2);
    check("t1_issue0", issue_instr_q[i0], I_ADD);
    check("t1_issue1", issue_instr_q[i0+1], I_SUB);
    check("t1_fetch_cnt", fetch_addr_q.size() - f0, 3);
    check("t1_fetch_pc0", fetch_addr_q[f0], 8'h00);
    check("t1_fetch_pc1", fetch_addr_q[f0+1], 8'h01);
    check("t1_fetch_pc2", fetch_addr_q[f0+2], 8'h02);

    // four warps, ADD then HALT each
    mark();
    start_run(4'b1111, 8'h10);
    wait_done("t2_done", 60);
    tick(1);
    check("t2_issue_cnt", issue_warp_q.size() - i0, 4);
    for (int k = 0; k < 4; k++) check("t2_issue_order", issue_warp_q[i0+k], k);
    check("t2_fetch_cnt", fetch_warp_q.size() - fw0, 8);
    for (int k = 0; k < 8; k++) check("t2_fetch_order", fetch_warp_q[fw0+k], k % 4);
    check("t2_done_cnt", done_cnt - d0c, 1);

    // stalled issue port holds the offered instruction
    mark();
    bus.issue_ready = 1'b0;
    start_run(4'b0011, 8'h10);
    for (int i = 0; i < 10; i++) begin
      if (bus.issue_valid) break;
      tick(1);
    end
    check("t3_valid_up", bus.issue_valid, 1);
    for (int k = 0; k < 5; k++) begin
      check("t3_hold", {bus.issue_valid, bus.issue_warp, bus.issue_instr}, {1'b1, 2'd0, I_ADD});
      tick(1);
    end
    check("t3_no_issue_while_stalled", issue_warp_q.size() - i0, 0);
    bus.issue_ready = 1'b1;
    wait_done("t3_done", 40);
    tick(1);
    check("t3_issue_cnt", issue_warp_q.size() - i0, 2);
    check("t3_issue_w0", issue_warp_q[i0], 0);
    check("t3_issue_w1", issue_warp_q[i0+1], 1);

    // pc wraps from FF to 00
    mem[0] = I_HALT;
    mark();
    start_run(4'b0001, 8'hFF);
    wait_done("t4_done", 30);
    tick(1);
    check("t4_fetch_cnt", fetch_addr_q.size() - f0, 2);
    check("t4_fetch_ff", fetch_addr_q[f0], 8'hFF);
    check("t4_fetch_wrap", fetch_addr_q[f0+1], 8'h00);
    check("t4_issue_cnt", issue_warp_q.size() - i0, 1);

    // writeback for a READY warp is a violation; err is sticky
    check("t5_err_clear", bus.err, 0);
    start_run(4'b0011, 8'h10);
    stray_wb = 1'b1; stray_wb_warp = 2'd1;
    tick(1);
    stray_wb = 1'b0;
    check("t5_err_set", bus.err, 1);
    wait_done("t5_done", 40);
    tick(1);
    check("t5_err_sticky", bus.err, 1);
    mark();
    start_run(4'b0000, 8'h00);
    check("t5_mask0_done", bus.done, 1);
    check("t5_mask0_busy", bus.busy, 0);
    check("t5_mask0_err_cleared", bus.err, 0);
    tick(1);
    check("t5_mask0_done_fall", bus.done, 0);
    tick(3);
    check("t5_mask0_no_fetch", fetch_addr_q.size() - f0, 0);
    stray_imem = 1'b1;
    tick(1);
    stray_imem = 1'b0;
    tick(1);
    check("t5_stray_imem_err", bus.err, 1);

    // reset while warp 2 executes
    wb_en = 1'b0;
    start_run(4'b0100, 8'h10);
    for (int i = 0; i < 10; i++) begin
      if (bus.dbg_state[2] == WS_EXEC) break;
      tick(1);
    end
    check("t6_w2_exec", bus.dbg_state[2], WS_EXEC);
    mark();
    reset = 1'b0;
    #1;
    check("t6_rst_req", bus.imem_req, 0);
    check("t6_rst_addr", bus.imem_addr, 0);
    check("t6_rst_issue", {bus.issue_valid, bus.issue_warp, bus.issue_instr}, 0);
    check("t6_rst_flags", {bus.busy, bus.done, bus.err}, 0);
    check("t6_rst_states", bus.dbg_state, 0);
    tick(2);
    reset = 1'b1;
    tick(1);
    check("t6_no_done", done_cnt - d0c, 0);
    wb_en = 1'b1;
    stray_wb = 1'b1; stray_wb_warp = 2'd2;
    tick(1);
    stray_wb = 1'b0;
    check("t6_late_wb_err", bus.err, 1);
    mark();
    start_run(4'b0100, 8'h10);
    check("t6_restart_err", bus.err, 0);
    check("t6_restart_addr", {bus.imem_req, bus.imem_addr}, {1'b1, 8'h10});
    wait_done("t6_done", 40);
    tick(1);
    check("t6_issue_cnt", issue_warp_q.size() - i0, 1);
    check("t6_issue_warp", issue_warp_q[i0], 2);
    check("t6_done_cnt", done_cnt - d0c, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
